mul_add_tree: RTL and testbench

- Unsigned WIDTH x WIDTH multiplier built as a shift-and-add partial-product tree, pipelined over two register stages.
- Used as a small arithmetic datapath element; default build is 4x4 -> 8-bit product.
- Accepts one operand pair per clock and has a valid flag travelling alongside the data.

---
 rtl/mul_add_tree.sv | 90 +++++++++
 tb/tb_mul_add_tree.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mul_add_tree.sv
// Unsigned WIDTH x WIDTH multiplier built from a shift-and-add partial-product tree.
// Stage 1 registers pairwise sums of the partial products.
// Stage 2 registers the balanced adder-tree total of those pair sums.
// A valid flag travels alongside the data.
// The datapath registers are never gated by in_valid, so mul_out always reflects
// the operands from two cycles earlier. Consumers qualify it with out_valid.
module mul_add_tree #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   mul_a,
    input  logic [WIDTH-1:0]   mul_b,
    output logic [2*WIDTH-1:0] mul_out,
    output logic               out_valid
);

    localparam int PW = 2 * WIDTH;   // product width
    localparam int NP = WIDTH / 2;   // number of stage-1 pair sums

    logic [PW-1:0] pp          [WIDTH];
    logic [PW-1:0] s1_next     [NP];
    logic [PW-1:0] s1_reg      [NP];
    logic [PW-1:0] tree_node   [NP];
    logic [PW-1:0] mul_out_next;
    logic [PW-1:0] mul_out_reg;
    logic          v1_reg;
    logic          out_valid_reg;

    // Partial products: row i is mul_a gated by bit i of mul_b.
    // Each row is zero-extended to the product width, then shifted left by i.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = {{WIDTH{1'b0}}, (mul_b[gi] ? mul_a : {WIDTH{1'b0}})} << gi;
        end
    endgenerate

    // Stage 1: each register holds the sum of two adjacent partial-product rows.
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_stage1
            assign s1_next[gi] = pp[2*gi] + pp[2*gi+1];

            // Pair-sum register. It captures every cycle; in_valid does not gate it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_reg[gi] <= '0;
                end else begin
                    s1_reg[gi] <= s1_next[gi];
                end
            end
        end
    endgenerate

    // Balanced binary reduction of the pair sums.
    // NP is a power of two, so every level pairs up evenly.
    always_comb begin
        tree_node = s1_reg;
        for (int step = 1; step < NP; step = step * 2) begin
            for (int j = 0; j + step < NP; j = j + 2 * step) begin
                tree_node[j] = tree_node[j] + tree_node[j+step];
            end
        end
        mul_out_next = tree_node[0];
    end

    // Stage-1 valid flag, delayed alongside the pair sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg <= 1'b0;
        end else begin
            v1_reg <= in_valid;
        end
    end

    // Stage 2: final product and its valid flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_out_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            mul_out_reg   <= mul_out_next;
            out_valid_reg <= v1_reg;
        end
    end

    assign mul_out   = mul_out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mul_add_tree.sv
// Directed testbench for mul_add_tree (WIDTH = 4).
// Each driven pair pushes its expected result into a scoreboard queue.
// The entry is popped and compared when that pair reaches the output, two edges later.
module tb_mul_add_tree;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    typedef struct {
        logic          v;
        logic [PW-1:0] p;
        string         tag;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [PW-1:0] mul_out;
    logic          out_valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mul_add_tree #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input exp_t e);
        checks++;
        assert (out_valid === e.v) else begin
            errors++;
            $error("FAIL %s out_valid got %0b expected %0b", e.tag, out_valid, e.v);
        end
        checks++;
        assert (mul_out === e.p) else begin
            errors++;
            $error("FAIL %s mul_out got %0d expected %0d", e.tag, mul_out, e.p);
        end
        $display("txn %s: out_valid=%0b mul_out=%0d (expected %0b/%0d)",
                 e.tag, out_valid, mul_out, e.v, e.p);
    endtask

    // Drive one pair for one cycle and record its expected result.
    // After the edge, compare the result that is due two edges after its own drive.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic v, input string tag);
        exp_t e;
        @(negedge clk);
        mul_a    = a;
        mul_b    = b;
        in_valid = v;
        e.v   = v;
        e.p   = PW'(a) * PW'(b);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            check_out(e);
        end
    endtask

    // Hold reset low for n edges and check that the outputs are cleared after each edge.
    // Release reset right after the last edge so the next step lines up.
    task automatic do_reset(input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            e.v   = 1'b0;
            e.p   = '0;
            e.tag = $sformatf("%s_rst%0d", tag, i);
            check_out(e);
        end
        sb.delete();
        // First edge after release: stage 1 still holds its cleared value.
        e.v   = 1'b0;
        e.p   = '0;
        e.tag = $sformatf("%s_post", tag);
        sb.push_back(e);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mul_a    = '0;
        mul_b    = '0;

        do_reset(2, "init");

        // Incrementing square sweep.
        for (int k = 0; k < 10; k++)
            step(W'(k), W'(k), 1'b1, $sformatf("sq%0d", k));

        // Corner operands.
        step(4'd15, 4'd15, 1'b1, "c15x15");
        step(4'd15, 4'd0,  1'b1, "c15x0");
        step(4'd0,  4'd15, 1'b1, "c0x15");
        step(4'd1,  4'd15, 1'b1, "c1x15");
        step(4'd8,  4'd8,  1'b1, "c8x8");

        // Back-to-back distinct pairs.
        step(4'd3,  4'd5,  1'b1, "b3x5");
        step(4'd7,  4'd9,  1'b1, "b7x9");
        step(4'd12, 4'd13, 1'b1, "b12x13");

        // Valid gating: the datapath still carries the invalid pair's product.
        step(4'd6, 4'd7, 1'b0, "g6x7_inv");
        step(4'd2, 4'd3, 1'b1, "g2x3");

        // Mid-operation reset: 9x9 is launched, then reset hits on the next edge.
        step(4'd9, 4'd9, 1'b1, "r9x9");
        do_reset(1, "mid");
        step(4'd0, 4'd0, 1'b0, "after_mid0");
        step(4'd0, 4'd0, 1'b0, "after_mid1");

        // Long reset.
        do_reset(4, "long");

        // Exhaustive sweep of all 256 operand pairs.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                step(W'(a), W'(b), 1'b1, $sformatf("x%0dx%0d", a, b));

        // Drain the pipeline.
        step(4'd0, 4'd0, 1'b0, "drain0");
        step(4'd0, 4'd0, 1'b0, "drain1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
